// File: rtl/gam_recall_pattern_loader.sv
// ----------------------------------------------------------------------------
// gam_recall_pattern_loader
//
// Front end of the GAM auto-associative recall stage. A serial element stream
// (valid/ready, in_last marks the final element) is gathered into a shadow
// vector. On a correctly sized pattern, the shadow vector, the threshold and
// the mode are copied to the outputs in one step. The loader then holds them
// stable for SETTLE_CYCLES so the combinational min-ED search can resolve.
// After that it raises pattern_valid_o until the consumer acknowledges.
// A short or long pattern produces a one-cycle err_len_o pulse and is dropped.
//
// Ports
//   clk_i              clock, all state on posedge
//   reset_i            synchronous active-high reset
//   in_valid_i         element beat valid
//   in_ready_o         element beat accepted when in_valid_i & in_ready_o
//   in_data_i [31:0]   pattern element
//   in_last_i          final element of a pattern
//   mode_in_i          mode for the pattern (0 = LEARNING, 1 = RECALL), first beat
//   tk_in_i   [31:0]   recall threshold, sampled on first beat
//   x_o       [DIM]    assembled pattern, element 0 = first beat
//   tk_o      [31:0]   latched threshold
//   learning_recall_o  mode driven to the recall stage
//   pattern_valid_o    recall result for x_o is settled
//   pattern_ack_i      consumer done with the current pattern
//   err_len_o          one-cycle pulse on a malformed pattern length
// ----------------------------------------------------------------------------
module gam_recall_pattern_loader #(
  parameter int DIM           = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           in_data_i,
  input  logic                  in_last_i,
  input  logic                  mode_in_i,
  input  logic [31:0]           tk_in_i,
  output logic [DIM-1:0][31:0]  x_o,
  output logic [31:0]           tk_o,
  output logic                  learning_recall_o,
  output logic                  pattern_valid_o,
  input  logic                  pattern_ack_i,
  output logic                  err_len_o
);

  localparam int IDX_W  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_SETTLE  = 2'd2;
  localparam logic [1:0] ST_PRESENT = 2'd3;

  localparam logic LEARNING = 1'b0;
  localparam logic RECALL   = 1'b1;

  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIM - 1);
  localparam logic [SCNT_W-1:0] SCNT_START = SCNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SCNT_W-1:0]    scnt_q, scnt_d;
  logic [DIM-1:0][31:0] shadow_q, shadow_d;
  logic                 smode_q, smode_d;
  logic [31:0]          stk_q, stk_d;
  logic [DIM-1:0][31:0] x_q, x_d;
  logic [31:0]          tk_q, tk_d;
  logic                 lr_q, lr_d;
  logic                 pv_q, pv_d;
  logic                 err_q, err_d;

  // Shadow vector with the current beat merged in. Feeding this (not
  // shadow_q) into x on the completion edge lets the last element land in x
  // on the same edge it is accepted.
  logic [DIM-1:0][31:0] shadow_wr;

  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_elem
      assign shadow_wr[gi] = (idx_q == IDX_W'(gi)) ? in_data_i : shadow_q[gi];
    end
  endgenerate

  logic beat;
  logic first_mode;
  logic [31:0] first_tk;

  assign in_ready_o = ((state_q == ST_COLLECT) || (state_q == ST_DRAIN)) && !reset_i;
  assign beat       = in_valid_i && in_ready_o;

  // On a one-beat pattern the shadow mode/threshold are not yet loaded, so
  // take the live inputs when the current beat is also the first.
  assign first_mode = (idx_q == '0) ? mode_in_i : smode_q;
  assign first_tk   = (idx_q == '0) ? tk_in_i   : stk_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    scnt_d   = scnt_q;
    shadow_d = shadow_q;
    smode_d  = smode_q;
    stk_d    = stk_q;
    x_d      = x_q;
    tk_d     = tk_q;
    lr_d     = lr_q;
    pv_d     = pv_q;
    err_d    = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (beat) begin
          shadow_d = shadow_wr;
          if (idx_q == '0) begin
            smode_d = mode_in_i;
            stk_d   = tk_in_i;
          end
          if (in_last_i) begin
            idx_d = '0;
            if (idx_q == IDX_LAST) begin
              x_d     = shadow_wr;
              tk_d    = first_tk;
              lr_d    = first_mode;
              scnt_d  = SCNT_START;
              state_d = ST_SETTLE;
            end else begin
              // Too short: drop it, x and Tk keep the previous pattern.
              err_d = 1'b1;
            end
          end else if (idx_q == IDX_LAST) begin
            // Too long: swallow the remainder up to its in_last.
            err_d   = 1'b1;
            idx_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (beat && in_last_i) begin
          idx_d   = '0;
          state_d = ST_COLLECT;
        end
      end

      ST_SETTLE: begin
        if (scnt_q == '0) begin
          pv_d    = 1'b1;
          state_d = ST_PRESENT;
        end else begin
          scnt_d = scnt_q - SCNT_W'(1);
        end
      end

      ST_PRESENT: begin
        if (pattern_ack_i) begin
          pv_d    = 1'b0;
          lr_d    = LEARNING;
          state_d = ST_COLLECT;
        end
      end

      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_COLLECT;
      idx_q    <= '0;
      scnt_q   <= '0;
      shadow_q <= '0;
      smode_q  <= LEARNING;
      stk_q    <= '0;
      x_q      <= '0;
      tk_q     <= '0;
      lr_q     <= LEARNING;
      pv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      scnt_q   <= scnt_d;
      shadow_q <= shadow_d;
      smode_q  <= smode_d;
      stk_q    <= stk_d;
      x_q      <= x_d;
      tk_q     <= tk_d;
      lr_q     <= lr_d;
      pv_q     <= pv_d;
      err_q    <= err_d;
    end
  end

  assign x_o               = x_q;
  assign tk_o              = tk_q;
  assign learning_recall_o = lr_q;
  assign pattern_valid_o   = pv_q;
  assign err_len_o         = err_q;

  // RECALL is only ever driven through first_mode; keep the name for readers.
  logic unused_recall;
  assign unused_recall = RECALL;

endmodule

// File: tb/tb_gam_recall_pattern_loader.sv
// ----------------------------------------------------------------------------
// Directed testbench for gam_recall_pattern_loader (DIM=16, SETTLE_CYCLES=2).
// Inputs are driven 1 ns after each rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_gam_recall_pattern_loader;

  localparam int DIM = 16;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_data;
  logic                  in_last;
  logic                  mode_in;
  logic [31:0]           tk_in;
  logic [DIM-1:0][31:0]  x;
  logic [31:0]           tk;
  logic                  lr;
  logic                  pv;
  logic                  pattern_ack;
  logic                  err_len;

  int checks = 0;
  int errors = 0;

  gam_recall_pattern_loader #(.DIM(DIM), .SETTLE_CYCLES(2)) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .in_data_i         (in_data),
    .in_last_i         (in_last),
    .mode_in_i         (mode_in),
    .tk_in_i           (tk_in),
    .x_o               (x),
    .tk_o              (tk),
    .learning_recall_o (lr),
    .pattern_valid_o   (pv),
    .pattern_ack_i     (pattern_ack),
    .err_len_o         (err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected vector: element i holds base+i+1.
  function automatic logic [511:0] make_vec(input int base);
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < DIM; i++) v[i*32 +: 32] = 32'(base + i + 1);
    return v;
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic last, input logic [31:0] t,
                           input logic m, input bit gap);
    int waited;
    if (gap) begin
      repeat ($urandom_range(0, 1)) begin
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tk_in    = t;
    mode_in  = m;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) chk("beat_timeout", 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Threshold and mode change after the first beat; the loader must keep the
  // first-beat values.
  task automatic send_pattern(input int base, input int n, input logic [31:0] t,
                              input logic m, input bit gap);
    for (int k = 0; k < n; k++)
      send_beat(32'(base + k + 1), (k == n - 1), (k == 0) ? t : t + 32'd1000,
                (k == 0) ? m : ~m, gap);
  endtask

  task automatic wait_valid();
    int waited = 0;
    while (!pv && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) chk("pv_timeout", 1'b0, 1'b1);
  endtask

  task automatic ack_pattern();
    pattern_ack = 1'b1;
    tick();
    pattern_ack = 1'b0;
    chk("ack_pv", pv, 1'b0);
    chk("ack_lr", lr, 1'b0);
  endtask

  task automatic reset_and_check(input string where);
    reset = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({where, "_x"}, x, '0);
    chk({where, "_tk"}, tk, 32'd0);
    chk({where, "_lr"}, lr, 1'b0);
    chk({where, "_pv"}, pv, 1'b0);
    chk({where, "_err"}, err_len, 1'b0);
    chk({where, "_rdy"}, in_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk({where, "_rdy_rel"}, in_ready, 1'b1);
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    mode_in     = 1'b0;
    tk_in       = '0;
    pattern_ack = 1'b0;
    repeat (3) tick();
    reset_and_check("rst0");

    // 1: nominal 16-beat pattern, RECALL, Tk=50
    send_pattern(0, 16, 32'd50, 1'b1, 1'b0);
    chk("t1_x", x, make_vec(0));
    chk("t1_tk", tk, 32'd50);
    chk("t1_lr", lr, 1'b1);
    chk("t1_pv_e0", pv, 1'b0);
    chk("t1_rdy_settle", in_ready, 1'b0);
    chk("t1_err", err_len, 1'b0);
    tick();
    chk("t1_pv_e1", pv, 1'b0);
    tick();
    chk("t1_pv_e2", pv, 1'b1);

    // 2: hold in PRESENT without ack
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t2_pv", pv, 1'b1);
      chk("t2_x", x, make_vec(0));
      chk("t2_tk", tk, 32'd50);
    end
    ack_pattern();
    chk("t2_rdy", in_ready, 1'b1);
    chk("t2_x_kept", x, make_vec(0));

    // 3: short pattern then a normal one
    send_pattern(100, 5, 32'd7, 1'b1, 1'b0);
    chk("t3_err", err_len, 1'b1);
    chk("t3_x_kept", x, make_vec(0));
    chk("t3_tk_kept", tk, 32'd50);
    tick();
    chk("t3_err_pulse", err_len, 1'b0);
    send_pattern(200, 16, 32'd77, 1'b1, 1'b0);
    chk("t3_x", x, make_vec(200));
    chk("t3_tk", tk, 32'd77);
    wait_valid();
    ack_pattern();

    // 4: long pattern of 20 beats, then a LEARNING pattern
    for (int k = 0; k < 20; k++) begin
      send_beat(32'(300 + k + 1), (k == 19), 32'd5, 1'b1, 1'b0);
      if (k == 15) chk("t4_err", err_len, 1'b1);
      else         chk("t4_noerr", err_len, 1'b0);
    end
    chk("t4_x_kept", x, make_vec(200));
    chk("t4_rdy", in_ready, 1'b1);
    send_pattern(400, 16, 32'd88, 1'b0, 1'b0);
    chk("t4_x", x, make_vec(400));
    chk("t4_tk", tk, 32'd88);
    chk("t4_lr", lr, 1'b0);
    wait_valid();
    chk("t4_pv", pv, 1'b1);
    ack_pattern();

    // 5: random gaps, threshold changes after the first beat
    send_pattern(500, 16, 32'd1234, 1'b1, 1'b1);
    chk("t5_x", x, make_vec(500));
    chk("t5_tk", tk, 32'd1234);
    chk("t5_lr", lr, 1'b1);
    wait_valid();
    ack_pattern();

    // 6: reset mid-pattern, in SETTLE, in PRESENT
    for (int k = 0; k < 7; k++) send_beat(32'(600 + k + 1), 1'b0, 32'd3, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'd608;
    reset_and_check("t6_mid");
    send_pattern(700, 16, 32'd9, 1'b1, 1'b0);
    reset_and_check("t6_settle");
    send_pattern(800, 16, 32'd11, 1'b1, 1'b0);
    wait_valid();
    reset_and_check("t6_present");
    send_pattern(900, 16, 32'd42, 1'b1, 1'b1);
    chk("t6_x", x, make_vec(900));
    chk("t6_tk", tk, 32'd42);
    wait_valid();
    chk("t6_pv", pv, 1'b1);
    ack_pattern();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
